// File: rtl/lsu_arbiter.sv
// rtl/lsu_arbiter.sv - two-port LSU arbiter/sequencer with region decode and load extension.
// Optional feature macro: LSU_ARB_MISALIGN_EN (misaligned half/word passed to the LSU as one access).
module lsu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_req,
  input  logic [11:0] i_a_addr,
  input  logic        i_a_wren,
  input  logic [1:0]  i_a_size,
  input  logic        i_a_unsigned,
  input  logic [31:0] i_a_wdata,
  input  logic        i_b_req,
  input  logic [11:0] i_b_addr,
  input  logic        i_b_wren,
  input  logic [1:0]  i_b_size,
  input  logic        i_b_unsigned,
  input  logic [31:0] i_b_wdata,
  output logic        o_a_gnt,
  output logic        o_a_rvalid,
  output logic [31:0] o_a_rdata,
  output logic        o_a_err,
  output logic        o_b_gnt,
  output logic        o_b_rvalid,
  output logic [31:0] o_b_rdata,
  output logic        o_b_err,
  output logic [11:0] o_lsu_addr,
  output logic        o_lsu_wren,
  output logic [1:0]  o_lsu_size,
  output logic [31:0] o_lsu_wdata,
  output logic [2:0]  o_lsu_cs,
  input  logic [31:0] i_lsu_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic        wren_q, wren_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic        port_q, port_d;
  logic        prio_b_q, prio_b_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        grant_a, grant_b;
  logic [1:0]  nbytes_m1;
  logic [12:0] last_byte;
  logic [2:0]  region;
  logic        misalign, legal;
  logic [31:0] load_ext;

  // prio_b_q set means A was granted last, so B wins the next conflict.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == S_IDLE) begin
      if (i_a_req && i_b_req) begin
        if (FIXED_PRIO || !prio_b_q) grant_a = 1'b1;
        else                         grant_b = 1'b1;
      end else begin
        grant_a = i_a_req;
        grant_b = i_b_req;
      end
    end
  end

  assign o_a_gnt = grant_a;
  assign o_b_gnt = grant_b;

  // Both the first and last byte must sit in one region; 13 bits keep addr+3 from wrapping.
  always_comb begin
    case (size_q)
      2'b01:   nbytes_m1 = 2'd1;
      2'b10:   nbytes_m1 = 2'd3;
      default: nbytes_m1 = 2'd0;
    endcase
    last_byte = {1'b0, addr_q} + {11'd0, nbytes_m1};
    region    = 3'b000;
    if (last_byte <= 13'h7FF)                              region = 3'b001;
    else if (addr_q >= 12'h800 && last_byte <= 13'h83F)    region = 3'b010;
    else if (addr_q >= 12'h900 && last_byte <= 13'h91F)    region = 3'b100;
  end

`ifdef LSU_ARB_MISALIGN_EN
  assign misalign = 1'b0;
`else
  assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`endif

  assign legal = (size_q != 2'b11) && (region != 3'b000) &&
                 !(wren_q && region[2]) && !misalign;

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & i_lsu_rdata[7]}}, i_lsu_rdata[7:0]};
      2'b01:   load_ext = {{16{~uns_q & i_lsu_rdata[15]}}, i_lsu_rdata[15:0]};
      default: load_ext = i_lsu_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wren_q   <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      port_q   <= 1'b0;
      prio_b_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wren_q   <= wren_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      port_q   <= port_d;
      prio_b_q <= prio_b_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_a || grant_b) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    wren_d   = wren_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    port_d   = port_q;
    prio_b_d = prio_b_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (grant_a || grant_b) begin
      port_d   = grant_b;
      prio_b_d = grant_a;
      addr_d   = grant_b ? i_b_addr     : i_a_addr;
      wren_d   = grant_b ? i_b_wren     : i_a_wren;
      size_d   = grant_b ? i_b_size     : i_a_size;
      uns_d    = grant_b ? i_b_unsigned : i_a_unsigned;
      wdata_d  = grant_b ? i_b_wdata    : i_a_wdata;
    end
    if (state_q == S_ACCESS) begin
      rdata_d = (legal && !wren_q) ? load_ext : 32'd0;
      err_d   = ~legal;
    end
  end

  always_comb begin
    o_lsu_addr  = '0;
    o_lsu_wren  = 1'b0;
    o_lsu_size  = '0;
    o_lsu_wdata = '0;
    o_lsu_cs    = '0;
    o_a_rvalid  = 1'b0;
    o_a_rdata   = '0;
    o_a_err     = 1'b0;
    o_b_rvalid  = 1'b0;
    o_b_rdata   = '0;
    o_b_err     = 1'b0;
    case (state_q)
      S_ACCESS: begin
        o_lsu_addr  = addr_q;
        o_lsu_size  = size_q;
        o_lsu_wdata = wdata_q;
        o_lsu_wren  = wren_q && legal;
        o_lsu_cs    = legal ? region : 3'b000;
      end
      S_RESP: begin
        if (port_q) begin
          o_b_rvalid = 1'b1;
          o_b_rdata  = rdata_q;
          o_b_err    = err_q;
        end else begin
          o_a_rvalid = 1'b1;
          o_a_rdata  = rdata_q;
          o_a_err    = err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb/tb_lsu_arbiter.sv - directed bench for lsu_arbiter with a transaction-level reference model.
module tb_lsu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req = 0, b_req = 0, a_wren = 0, b_wren = 0, a_uns = 0, b_uns = 0;
  logic [11:0] a_addr = 0, b_addr = 0;
  logic [1:0]  a_size = 0, b_size = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [11:0] lsu_addr;
  logic        lsu_wren;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_wdata, lsu_rdata;
  logic [2:0]  lsu_cs;

  logic        f_a_req = 0, f_b_req = 0;
  logic        f_a_gnt, f_b_gnt, f_a_rvalid, f_b_rvalid, f_a_err, f_b_err, f_lsu_wren;
  logic [31:0] f_a_rdata, f_b_rdata, f_lsu_wdata;
  logic [11:0] f_lsu_addr;
  logic [1:0]  f_lsu_size;
  logic [2:0]  f_lsu_cs;

  lsu_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_addr(a_addr), .i_a_wren(a_wren), .i_a_size(a_size),
    .i_a_unsigned(a_uns), .i_a_wdata(a_wdata),
    .i_b_req(b_req), .i_b_addr(b_addr), .i_b_wren(b_wren), .i_b_size(b_size),
    .i_b_unsigned(b_uns), .i_b_wdata(b_wdata),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata), .o_a_err(a_err),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata), .o_b_err(b_err),
    .o_lsu_addr(lsu_addr), .o_lsu_wren(lsu_wren), .o_lsu_size(lsu_size),
    .o_lsu_wdata(lsu_wdata), .o_lsu_cs(lsu_cs), .i_lsu_rdata(lsu_rdata)
  );

  lsu_arbiter #(.FIXED_PRIO(1'b1)) u_fix (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(f_a_req), .i_a_addr(12'h000), .i_a_wren(1'b0), .i_a_size(2'b10),
    .i_a_unsigned(1'b0), .i_a_wdata(32'd0),
    .i_b_req(f_b_req), .i_b_addr(12'h000), .i_b_wren(1'b0), .i_b_size(2'b10),
    .i_b_unsigned(1'b0), .i_b_wdata(32'd0),
    .o_a_gnt(f_a_gnt), .o_a_rvalid(f_a_rvalid), .o_a_rdata(f_a_rdata), .o_a_err(f_a_err),
    .o_b_gnt(f_b_gnt), .o_b_rvalid(f_b_rvalid), .o_b_rdata(f_b_rdata), .o_b_err(f_b_err),
    .o_lsu_addr(f_lsu_addr), .o_lsu_wren(f_lsu_wren), .o_lsu_size(f_lsu_size),
    .o_lsu_wdata(f_lsu_wdata), .o_lsu_cs(f_lsu_cs), .i_lsu_rdata(32'd0)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // LSU memory behind the DUT: combinational read, write committed at the end of the access cycle.
  logic [7:0]  lsu_mem [4096];
  bit          mem_ready = 0;
  bit          wr_pend = 0;
  logic [11:0] wr_addr;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;

  assign lsu_rdata = {lsu_mem[lsu_addr + 12'd3], lsu_mem[lsu_addr + 12'd2],
                      lsu_mem[lsu_addr + 12'd1], lsu_mem[lsu_addr]};

  always @(negedge clk) begin
    wr_pend = rst_n && lsu_wren;
    wr_addr = lsu_addr;
    wr_size = lsu_size;
    wr_data = lsu_wdata;
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) lsu_mem[i] = 8'h00;
      for (int i = 0; i < 32; i++) lsu_mem[12'h900 + i] = 8'(8'h10 + i);
      mem_ready = 1;
    end
    if (wr_pend && rst_n)
      for (int i = 0; i < (1 << wr_size); i++) lsu_mem[12'(wr_addr + i)] = wr_data[8*i +: 8];
  end

  // Reference model: one transaction in flight, response two cycles after its grant.
  logic [7:0] ref_mem [4096];
  int cyc = 0;
  bit last_b = 1;
  bit p_valid = 0, p_port, p_wren, p_uns, p_legal;
  int p_cyc, p_addr;
  logic [1:0]  p_size;
  logic [31:0] p_wdata;
  logic [2:0]  p_cs;
  int gq[$];

  function automatic logic [2:0] m_region(input int a, input int n);
    int last = a + n - 1;
    if (last <= 'h7FF) return 3'b001;
    if (a >= 'h800 && last <= 'h83F) return 3'b010;
    if (a >= 'h900 && last <= 'h91F) return 3'b100;
    return 3'b000;
  endfunction

  function automatic bit m_legal(input int a, input bit w, input logic [1:0] s);
    int n = 1 << s;
    logic [2:0] r = m_region(a, n);
    if (s == 2'b11 || r == 3'b000) return 0;
    if (w && r == 3'b100) return 0;
`ifndef LSU_ARB_MISALIGN_EN
    if (a % n != 0) return 0;
`endif
    return 1;
  endfunction

  function automatic logic [31:0] m_load(input int a, input logic [1:0] s, input bit u);
    int v = 0;
    int n = 1 << s;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + int'(ref_mem[(a + i) % 4096]);
    if (!u && n == 1 && v > 127) v -= 256;
    if (!u && n == 2 && v > 32767) v -= 65536;
    return 32'(v);
  endfunction

  always @(negedge clk) begin
    bit ea, eb, idle;
    logic [31:0] exp_rd;
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
      for (int i = 0; i < 32; i++) ref_mem['h900 + i] = 8'(8'h10 + i);
    end
    if (!rst_n) begin
      chk("rst_ctl", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, lsu_wren, lsu_cs}), 32'd0);
      chk("rst_rdata", a_rdata | b_rdata, 32'd0);
      p_valid = 0;
      last_b  = 1;
    end else begin
      idle = !p_valid;
      ea = idle && a_req && (!b_req || last_b);
      eb = idle && b_req && (!a_req || !last_b);
      chk("gnt", 32'({a_gnt, b_gnt}), 32'({ea, eb}));
      if (p_valid && cyc == p_cyc + 1) begin
        chk("lsu_cs", 32'(lsu_cs), 32'(p_legal ? p_cs : 3'b000));
        chk("lsu_wren", 32'(lsu_wren), 32'(p_legal && p_wren));
        if (p_legal) begin
          chk("lsu_addr", 32'(lsu_addr), 32'(p_addr));
          chk("lsu_size", 32'(lsu_size), 32'(p_size));
          if (p_wren) chk("lsu_wdata", lsu_wdata, p_wdata);
        end
      end else begin
        chk("lsu_quiet", 32'({lsu_wren, lsu_cs}), 32'd0);
      end
      if (p_valid && cyc == p_cyc + 2) begin
        exp_rd = (p_legal && !p_wren) ? m_load(p_addr, p_size, p_uns) : 32'd0;
        chk("rvalid", 32'({a_rvalid, b_rvalid}), p_port ? 32'd1 : 32'd2);
        chk("rdata", p_port ? b_rdata : a_rdata, exp_rd);
        chk("err", 32'(p_port ? b_err : a_err), 32'(!p_legal));
        if (p_legal && p_wren)
          for (int i = 0; i < (1 << p_size); i++) ref_mem[(p_addr + i) % 4096] = p_wdata[8*i +: 8];
        p_valid = 0;
      end else begin
        chk("rvalid_quiet", 32'({a_rvalid, b_rvalid}), 32'd0);
      end
      if (ea || eb) begin
        p_valid = 1;
        p_cyc   = cyc;
        p_port  = eb;
        p_addr  = int'(eb ? b_addr : a_addr);
        p_wren  = eb ? b_wren : a_wren;
        p_size  = eb ? b_size : a_size;
        p_uns   = eb ? b_uns : a_uns;
        p_wdata = eb ? b_wdata : a_wdata;
        p_cs    = m_region(p_addr, 1 << p_size);
        p_legal = m_legal(p_addr, p_wren, p_size);
        last_b  = eb;
      end
      if (a_gnt) gq.push_back(0);
      if (b_gnt) gq.push_back(1);
    end
    cyc++;
  end

  task automatic xfer(input bit port, input logic [11:0] addr, input bit wren,
                      input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                      output logic [31:0] rd, output bit er);
    bit got = 0, rv = 0;
    int lat = 1;
    rd = '0;
    er = 0;
    @(posedge clk);
    #1;
    if (port) begin
      b_addr = addr; b_wren = wren; b_size = size; b_uns = uns; b_wdata = wdata; b_req = 1;
    end else begin
      a_addr = addr; a_wren = wren; a_size = size; a_uns = uns; a_wdata = wdata; a_req = 1;
    end
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = port ? b_gnt : a_gnt;
    end
    chk("gnt_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (port) b_req = 0; else a_req = 0;
    for (int n = 0; n < 6 && !rv; n++) begin
      @(negedge clk);
      if (port ? b_rvalid : a_rvalid) begin
        rv = 1;
        rd = port ? b_rdata : a_rdata;
        er = port ? b_err : a_err;
      end else lat++;
    end
    chk("rvalid_seen", 32'(rv), 32'd1);
    if (got && rv) chk("latency", 32'(lat), 32'd2);
  endtask

  initial begin
    logic [31:0] rd, rd_a, rd_b;
    bit er, er_a, er_b, got;
    int fq[$];
    int na;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, lsu_wren, lsu_cs}), 32'd0);
    chk("reset_lsu", lsu_wdata | 32'(lsu_addr), 32'd0);
    rst_n = 1;

    xfer(0, 12'h010, 1, 2'b10, 0, 32'h0000_ABCD, rd, er);
    chk("t1_store_err", 32'(er), 32'd0);
    xfer(0, 12'h010, 0, 2'b10, 0, 32'd0, rd, er);
    chk("t1_load", rd, 32'h0000_ABCD);
    chk("t1_load_err", 32'(er), 32'd0);

    xfer(0, 12'h004, 1, 2'b00, 0, 32'h0000_0080, rd, er);
    xfer(0, 12'h004, 0, 2'b00, 0, 32'd0, rd, er);
    chk("t2_byte_s", rd, 32'hFFFF_FF80);
    xfer(1, 12'h004, 0, 2'b00, 1, 32'd0, rd, er);
    chk("t2_byte_u", rd, 32'h0000_0080);
    xfer(1, 12'h006, 1, 2'b01, 0, 32'h0000_8001, rd, er);
    xfer(1, 12'h006, 0, 2'b01, 0, 32'd0, rd, er);
    chk("t2_half_s", rd, 32'hFFFF_8001);
    xfer(0, 12'h004, 0, 2'b10, 0, 32'd0, rd, er);
    chk("t2_word", rd, 32'h8001_0080);

    xfer(0, 12'h900, 1, 2'b10, 0, 32'h1234_5678, rd, er);
    chk("t4_st_in_err", 32'(er), 32'd1);
    xfer(1, 12'hA00, 0, 2'b10, 0, 32'd0, rd, er);
    chk("t4_hole", {rd[30:0], er}, 32'd1);
    xfer(0, 12'h020, 0, 2'b11, 0, 32'd0, rd, er);
    chk("t4_size3", {rd[30:0], er}, 32'd1);
    xfer(0, 12'h904, 0, 2'b10, 0, 32'd0, rd, er);
    chk("t4_in_load", rd, 32'h1716_1514);

    xfer(0, 12'h800, 1, 2'b10, 0, 32'h1122_3344, rd, er);
    xfer(1, 12'h802, 0, 2'b10, 1, 32'd0, rd, er);
`ifdef LSU_ARB_MISALIGN_EN
    chk("t5_mis_err", 32'(er), 32'd0);
    chk("t5_mis_rd", rd, 32'h0000_1122);
`else
    chk("t5_mis_err", 32'(er), 32'd1);
    chk("t5_mis_rd", rd, 32'd0);
`endif
    xfer(0, 12'h7FE, 0, 2'b10, 0, 32'd0, rd, er);
    chk("t5_cross_data", 32'(er), 32'd1);
    xfer(0, 12'h83F, 0, 2'b01, 0, 32'd0, rd, er);
    chk("t5_cross_out", 32'(er), 32'd1);
    xfer(0, 12'h83F, 0, 2'b00, 0, 32'd0, rd, er);
    chk("t5_last_byte", 32'(er), 32'd0);

    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    gq.delete();
    fork
      repeat (4) xfer(0, 12'h040, 0, 2'b10, 0, 32'd0, rd_a, er_a);
      repeat (4) xfer(1, 12'h044, 0, 2'b10, 0, 32'd0, rd_b, er_b);
    join
    chk("t3_rr_count", 32'(gq.size()), 32'd8);
    for (int i = 0; i < gq.size(); i++) chk("t3_rr_order", 32'(gq[i]), 32'(i % 2));

    @(posedge clk);
    #1;
    f_a_req = 1;
    f_b_req = 1;
    na = 0;
    for (int n = 0; n < 60 && fq.size() < 5; n++) begin
      @(negedge clk);
      chk("fix_lsu", 32'({f_lsu_wren, f_lsu_addr}) | f_lsu_wdata, 32'd0);
      chk("fix_cs_size", 32'((f_lsu_cs == 0 && f_lsu_size == 0) || (f_lsu_cs == 1 && f_lsu_size == 2)), 32'd1);
      if (f_a_rvalid || f_b_rvalid) chk("fix_resp", 32'({f_a_err, f_b_err}) | f_a_rdata | f_b_rdata, 32'd0);
      if (f_a_gnt) begin fq.push_back(0); na++; end
      if (f_b_gnt) fq.push_back(1);
      if (na == 4 && f_a_req) begin
        @(posedge clk);
        #1 f_a_req = 0;
      end
    end
    @(posedge clk);
    #1 f_b_req = 0;
    chk("t3_fix_count", 32'(fq.size()), 32'd5);
    for (int i = 0; i < fq.size(); i++) chk("t3_fix_order", 32'(fq[i]), i == 4 ? 32'd1 : 32'd0);

    repeat (4) @(posedge clk);
    #1;
    a_addr = 12'h010; a_wren = 1; a_size = 2'b10; a_uns = 0; a_wdata = 32'hDEAD_BEEF; a_req = 1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = a_gnt;
    end
    chk("t6_gnt", 32'(got), 32'd1);
    @(posedge clk);
    #1 a_req = 0;
    chk("t6_wren_access", 32'(lsu_wren), 32'd1);
    #1 rst_n = 0;
    #1;
    chk("t6_rst_lsu", 32'({lsu_wren, lsu_cs, lsu_addr}), 32'd0);
    chk("t6_rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    xfer(0, 12'h010, 0, 2'b10, 0, 32'd0, rd, er);
    chk("t6_mem_kept", rd, 32'h0000_ABCD);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
